ramp_sar_adc_ctrl: RTL and testbench
====================================

RAMP_SAR_ADC_CTRL -- requirements
Module: ramp_sar_adc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, DAC/result code width in bits (4..16).
REQ-002 Parameter SETTLE_CYCLES, default 1000, clk cycles each DAC code is held before it is evaluated (minimum 4).
REQ-003 Parameter AVG_LOG2, default 2, log2 of the number of conversions averaged per result (0..4).
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; while high, conversions run back-to-back.
REQ-007 mode  in  1  0 = ramp conversion, 1 = successive-approximation (SAR) conversion; sampled in IDLE only.
REQ-008 comparator_in  in  1  asynchronous comparator output, high when Vin > Vdac.
REQ-009 dac_code  out  WIDTH  trial code sent to the PWM/R2R DAC.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 sample  out  WIDTH  averaged conversion result.
REQ-012 sample_valid  out  1  sample holds an unconsumed result.
REQ-013 sample_ready  in  1  consumer accepts sample when sample_valid && sample_ready.
REQ-014 timeout  out  1  sticky: the last ramp reached full scale without a comparator falling edge.

Function
REQ-015 comparator_in SHALL pass through a 2-flop synchronizer plus a previous-value flop; a falling edge is prev && !sync2.
REQ-016 FSM states: IDLE, SETTLE, DECIDE, ACCUM, HOLD.
REQ-017 IDLE -> SETTLE when start=1 and sample_valid=0; this transition latches mode, loads the first trial code, and clears the settle counter.
REQ-018 SETTLE holds dac_code for SETTLE_CYCLES cycles, then moves to DECIDE.
REQ-019 Ramp mode: first code is 0; code increments by 1 per step. A falling edge detected during SETTLE captures the current dac_code as the conversion result and goes to ACCUM. If code 2^WIDTH-1 completes without an edge, the result is all-ones, timeout is set, and the FSM goes to ACCUM.
REQ-020 SAR mode: first trial is MSB only. In DECIDE, the trial bit is kept if sync2=1 and cleared otherwise, then the next lower bit is set. After the LSB decision the result goes to ACCUM, giving exactly WIDTH steps.
REQ-021 ACCUM adds the result into a WIDTH+AVG_LOG2-bit accumulator. After 2^AVG_LOG2 conversions, sample = accumulator >> AVG_LOG2 (truncated), sample_valid is set, the accumulator clears, and the FSM goes to HOLD; otherwise it starts the next conversion in SETTLE.
REQ-022 HOLD -> IDLE in the cycle that sample_valid && sample_ready; sample_valid clears on that same edge.
REQ-023 While sample_valid=1, no new conversion starts (backpressure); results are never overwritten or dropped.
REQ-024 start falling mid-conversion does not abort; the current averaged result completes.
REQ-025 dac_code = 0 in IDLE and HOLD.
REQ-026 timeout clears at the start of each ramp conversion; it is never set in SAR mode.

Reset
REQ-027 Reset has priority over all other inputs and returns the FSM to IDLE at any state, including mid-conversion.
REQ-028 Reset clears dac_code, sample, sample_valid, busy, timeout, the accumulator, the counters, and the synchronizer flops to 0; any partial average is discarded.

Configuration
REQ-029 Macro ADC_AVG_EN defined: averaging over 2^AVG_LOG2 conversions as in REQ-021.
REQ-030 Macro ADC_AVG_EN undefined: AVG_LOG2 is ignored, every conversion produces a sample directly, and no accumulator is synthesized.

Structure
REQ-031 Package adc_pkg holds the FSM state enum, the mode encoding constants (MODE_RAMP=0, MODE_SAR=1), and the default WIDTH/SETTLE_CYCLES values.
REQ-032 Sub-module comp_sync implements the synchronizer and edge detector (outputs: sync level, falling-edge pulse) and is instantiated once.

Verification
All scenarios use WIDTH=8, SETTLE_CYCLES=4, and ADC_AVG_EN defined with AVG_LOG2=2 unless stated otherwise.
REQ-033 Ramp: mode=0, comparator model = (dac_code < 0x5A), start=1, ready=1 -> sample=0x5A, valid for 1 cycle, timeout=0.
REQ-034 SAR: mode=1, comparator model = (dac_code <= 0xB3) -> trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xB8, 0xB4, 0xB2, 0xB3; sample=0xB3 after 8 steps x 4 conversions.
REQ-035 Timeout: mode=0, comparator held at 1 -> sample=0xFF and timeout=1; then a ramp with the model (dac_code < 0x10) -> timeout=0, sample=0x10.
REQ-036 Averaging: SAR with the model threshold set to 0x10, 0x11, 0x12, 0x13 on successive conversions -> sample=0x11 (sum 0x46 >> 2).
REQ-037 Backpressure: ready=0 for 500 cycles after valid -> sample stable, busy=0, dac_code=0; raising ready clears valid and the next conversion starts.
REQ-038 Reset mid-SAR at step 5 -> next cycle all outputs are 0 and the FSM is IDLE; a subsequent conversion still yields the correct 0xB3.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ramp/SAR ADC controller.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_DECIDE = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_HOLD   = 3'd4
    } adc_state_e;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_SAR  = 1'b1;

    localparam int unsigned DEFAULT_WIDTH         = 8;
    localparam int unsigned DEFAULT_SETTLE_CYCLES = 1000;
    localparam int unsigned DEFAULT_AVG_LOG2      = 2;

endpackage

// File: rtl/comp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output, plus falling-edge detect.
module comp_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_level,
    output logic fall
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync_level = sync2;
    assign fall       = prev & ~sync2;

endmodule

// File: rtl/ramp_sar_adc_ctrl.sv
// Ramp / SAR ADC conversion controller with optional result averaging.
// Define ADC_AVG_EN to average 2^AVG_LOG2 conversions per sample; otherwise each conversion is a sample.
module ramp_sar_adc_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned AVG_LOG2      = DEFAULT_AVG_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             comparator_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             timeout
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH - 1){1'b0}}};

    if (WIDTH < 4 || WIDTH > 16 || SETTLE_CYCLES < 4 || AVG_LOG2 > 4) begin : g_param_check
        $error("ramp_sar_adc_ctrl: parameter out of range");
    end

    logic comp_level, comp_fall;

    comp_sync u_comp_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (comparator_in),
        .sync_level (comp_level),
        .fall       (comp_fall)
    );

    adc_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] trial;

`ifdef ADC_AVG_EN
    localparam int unsigned ACC_W  = WIDTH + AVG_LOG2;
    localparam int unsigned N_CONV = 1 << AVG_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [3:0]       conv_q, conv_d;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        code_d    = code_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        trial     = comp_level ? code_q : (code_q & ~bit_q);
`ifdef ADC_AVG_EN
        acc_d   = acc_q;
        conv_d  = conv_q;
        acc_sum = acc_q + ACC_W'(result_q);
`endif

        unique case (state_q)
            ST_IDLE: begin
                code_d = '0;
                if (start && !valid_q) begin
                    mode_d  = mode;
                    code_d  = (mode == MODE_SAR) ? MSB_ONLY : '0;
                    bit_d   = MSB_ONLY;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                    if (mode == MODE_RAMP) timeout_d = 1'b0;
                end
            end

            ST_SETTLE: begin
                // A ramp crossing is caught as soon as it reaches the synchronizer.
                if (mode_q == MODE_RAMP && comp_fall) begin
                    result_d = code_q;
                    state_d  = ST_ACCUM;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DECIDE: begin
                cnt_d = '0;
                if (mode_q == MODE_RAMP) begin
                    if (code_q == '1) begin
                        result_d  = '1;
                        timeout_d = 1'b1;
                        state_d   = ST_ACCUM;
                    end else begin
                        code_d  = code_q + WIDTH'(1);
                        state_d = ST_SETTLE;
                    end
                end else if (bit_q[0]) begin
                    code_d   = trial;
                    result_d = trial;
                    state_d  = ST_ACCUM;
                end else begin
                    code_d  = trial | (bit_q >> 1);
                    bit_d   = bit_q >> 1;
                    state_d = ST_SETTLE;
                end
            end

            ST_ACCUM: begin
`ifdef ADC_AVG_EN
                if (conv_q == 4'(N_CONV - 1)) begin
                    sample_d = WIDTH'(acc_sum >> AVG_LOG2);
                    valid_d  = 1'b1;
                    acc_d    = '0;
                    conv_d   = '0;
                    code_d   = '0;
                    state_d  = ST_HOLD;
                end else begin
                    acc_d   = acc_sum;
                    conv_d  = conv_q + 4'd1;
                    code_d  = (mode_q == MODE_SAR) ? MSB_ONLY : '0;
                    bit_d   = MSB_ONLY;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                    if (mode_q == MODE_RAMP) timeout_d = 1'b0;
                end
`else
                sample_d = result_q;
                valid_d  = 1'b1;
                code_d   = '0;
                state_d  = ST_HOLD;
`endif
            end

            ST_HOLD: begin
                code_d = '0;
                if (valid_q && sample_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_RAMP;
            code_q    <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            code_q    <= code_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ADC_AVG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            conv_q <= '0;
        end else begin
            acc_q  <= acc_d;
            conv_q <= conv_d;
        end
    end
`endif

    assign dac_code     = code_q;
    assign busy         = (state_q != ST_IDLE);
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_ramp_sar_adc_ctrl.sv
// Directed self-checking bench for ramp_sar_adc_ctrl (WIDTH=8, SETTLE_CYCLES=4, AVG_LOG2=2).
module tb_ramp_sar_adc_ctrl;

`ifdef ADC_AVG_EN
    localparam logic [7:0] AVG_EXP = 8'h11;
`else
    localparam logic [7:0] AVG_EXP = 8'h10;
`endif

    logic       clk = 1'b0;
    logic       reset, start, mode, sample_ready;
    logic       comparator_in;
    logic [7:0] dac_code, sample;
    logic       busy, sample_valid, timeout;

    // Comparator model: 0 -> dac < thr, 1 -> dac <= thr, 2 -> stuck high
    int         model_kind;
    logic [7:0] thr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign comparator_in = (model_kind == 2) ? 1'b1 :
                           (model_kind == 1) ? (dac_code <= thr) : (dac_code < thr);

    ramp_sar_adc_ctrl #(
        .WIDTH         (8),
        .SETTLE_CYCLES (4),
        .AVG_LOG2      (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .comparator_in (comparator_in),
        .dac_code      (dac_code),
        .busy          (busy),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .timeout       (timeout)
    );

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0; sample_ready = 1'b1;
        model_kind = 0; thr = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run += 5;
        if (dac_code !== 8'h00) begin tests_failed++; $display("FAIL reset_dac got %h want 00", dac_code); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        if (sample !== 8'h00) begin tests_failed++; $display("FAIL reset_sample got %h want 00", sample); end
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %b want 0", timeout); end
    endtask

    task automatic test_ramp();
        bit ok;
        model_kind = 0; thr = 8'h5A; mode = 1'b0; sample_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        tests_run += 2;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL ramp_busy got %b want 1", busy); end
        if (dac_code !== 8'h00) begin tests_failed++; $display("FAIL ramp_first got %h want 00", dac_code); end
        wait_valid(20000, ok);
        start = 1'b0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL ramp_wait got no valid want valid"); end
        tests_run += 2;
        if (sample !== 8'h5A) begin tests_failed++; $display("FAIL ramp_sample got %h want 5a", sample); end
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL ramp_timeout got %b want 0", timeout); end
        @(negedge clk);
        tests_run++;
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL ramp_valid_pulse got %b want 0", sample_valid); end
    endtask

    task automatic test_sar();
        logic [7:0] exp_tr [8];
        logic [7:0] got_tr [8];
        logic [7:0] last;
        int n;
        bit ok;
        exp_tr[0] = 8'h80; exp_tr[1] = 8'hC0; exp_tr[2] = 8'hA0; exp_tr[3] = 8'hB0;
        exp_tr[4] = 8'hB8; exp_tr[5] = 8'hB4; exp_tr[6] = 8'hB2; exp_tr[7] = 8'hB3;
        for (int i = 0; i < 8; i++) got_tr[i] = 8'h00;
        model_kind = 1; thr = 8'hB3; mode = 1'b1; sample_ready = 1'b1;
        last = dac_code; n = 0;
        start = 1'b1;
        for (int i = 0; i < 400 && n < 8; i++) begin
            @(negedge clk);
            mode = 1'b0;  // must be ignored once the conversion is running
            if (dac_code !== last) begin
                got_tr[n] = dac_code;
                last = dac_code;
                n++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got_tr[i] !== exp_tr[i]) begin
                tests_failed++;
                $display("FAIL sar_trial%0d got %h want %h", i, got_tr[i], exp_tr[i]);
            end
        end
        wait_valid(2000, ok);
        start = 1'b0;
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL sar_wait got no valid want valid"); end
        if (sample !== 8'hB3) begin tests_failed++; $display("FAIL sar_sample got %h want b3", sample); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        model_kind = 2; mode = 1'b0; sample_ready = 1'b1;
        start = 1'b1;
        wait_valid(30000, ok);
        start = 1'b0;
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL tmo_wait got no valid want valid"); end
        if (sample !== 8'hFF) begin tests_failed++; $display("FAIL tmo_sample got %h want ff", sample); end
        if (timeout !== 1'b1) begin tests_failed++; $display("FAIL tmo_flag got %b want 1", timeout); end
        @(negedge clk);
        model_kind = 0; thr = 8'h10;
        start = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear got %b want 0", timeout); end
        wait_valid(20000, ok);
        start = 1'b0;
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL tmo2_wait got no valid want valid"); end
        if (sample !== 8'h10) begin tests_failed++; $display("FAIL tmo2_sample got %h want 10", sample); end
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo2_flag got %b want 0", timeout); end
        @(negedge clk);
    endtask

    task automatic test_averaging();
        logic [7:0] tbl [4];
        logic [7:0] last;
        int k;
        bit ok;
        tbl[0] = 8'h10; tbl[1] = 8'h11; tbl[2] = 8'h12; tbl[3] = 8'h13;
        model_kind = 1; thr = tbl[0]; mode = 1'b1; sample_ready = 1'b1;
        last = dac_code; k = 0; ok = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            // Each new conversion begins at the MSB-only trial
            if (dac_code == 8'h80 && last != 8'h80 && k < 4) begin
                thr = tbl[k];
                k++;
            end
            last = dac_code;
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL avg_wait got no valid want valid"); end
        if (sample !== AVG_EXP) begin tests_failed++; $display("FAIL avg_sample got %h want %h", sample, AVG_EXP); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad_sample, bad_valid, bad_dac;
        bit ok;
        model_kind = 1; thr = 8'hB3; mode = 1'b1; sample_ready = 1'b0;
        bad_sample = 0; bad_valid = 0; bad_dac = 0;
        start = 1'b1;
        wait_valid(2000, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL bp_wait got no valid want valid"); end
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sample !== 8'hB3) bad_sample++;
            if (sample_valid !== 1'b1) bad_valid++;
            if (dac_code !== 8'h00) bad_dac++;
        end
        tests_run += 3;
        if (bad_sample != 0) begin tests_failed++; $display("FAIL bp_sample got %0d bad cycles want 0", bad_sample); end
        if (bad_valid != 0) begin tests_failed++; $display("FAIL bp_valid got %0d bad cycles want 0", bad_valid); end
        if (bad_dac != 0) begin tests_failed++; $display("FAIL bp_dac got %0d bad cycles want 0", bad_dac); end
        sample_ready = 1'b1;
        @(negedge clk);
        tests_run += 2;
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release got %b want 0", sample_valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle got %b want 0", busy); end
        @(negedge clk);
        tests_run += 2;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_restart_busy got %b want 1", busy); end
        if (dac_code !== 8'h80) begin tests_failed++; $display("FAIL bp_restart_dac got %h want 80", dac_code); end
        start = 1'b0;
        wait_valid(2000, ok);
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL bp2_wait got no valid want valid"); end
        if (sample !== 8'hB3) begin tests_failed++; $display("FAIL bp2_sample got %h want b3", sample); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sar();
        logic [7:0] last;
        int n;
        bit ok;
        model_kind = 1; thr = 8'hB3; mode = 1'b1; sample_ready = 1'b1;
        last = dac_code; n = 0;
        start = 1'b1;
        for (int i = 0; i < 400 && n < 5; i++) begin
            @(negedge clk);
            if (dac_code !== last) begin
                last = dac_code;
                n++;
            end
        end
        tests_run++;
        if (dac_code !== 8'hB8) begin tests_failed++; $display("FAIL rst_step5 got %h want b8", dac_code); end
        reset = 1'b1;
        @(negedge clk);
        tests_run += 5;
        if (dac_code !== 8'h00) begin tests_failed++; $display("FAIL rst_dac got %h want 00", dac_code); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", busy); end
        if (sample !== 8'h00) begin tests_failed++; $display("FAIL rst_sample got %h want 00", sample); end
        if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got %b want 0", sample_valid); end
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_timeout got %b want 0", timeout); end
        reset = 1'b0;
        wait_valid(2000, ok);
        start = 1'b0;
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL rst2_wait got no valid want valid"); end
        if (sample !== 8'hB3) begin tests_failed++; $display("FAIL rst2_sample got %h want b3", sample); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_sar();
        test_timeout();
        test_averaging();
        test_backpressure();
        test_reset_mid_sar();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
